// File: rtl/multi_pulse_generator.sv
// multi_pulse_generator
//
// Turns N raw, bouncy pad inputs (buttons/switches) into clean strobes. Each channel
// runs a 2-FF synchroniser, a counter-based debouncer, an edge detector selected by
// edge_mode and a pulse-stretcher FSM. Every qualifying debounced edge produces
// exactly one pulse of PW clk cycles on p.
//
// Ports:
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset, released synchronously by the caller
//   trigger    [N]  raw asynchronous inputs, one per channel
//   edge_mode  [2]  00 rising, 01 falling, 10 both, 11 disabled (quasi-static)
//   p          [N]  registered pulse outputs
//   level      [N]  registered debounced level per channel
//
// Optional feature: define MULTI_PULSE_AUTO_REPEAT_EN to add per-channel auto-repeat.
// In mode 00 (held high) or 01 (held low) a repeat pulse fires REPEAT_DELAY cycles after
// the qualifying edge, then every REPEAT_PERIOD cycles, until the level or mode changes.

module multi_pulse_generator #(
  parameter int unsigned N             = 4,
  parameter int unsigned DB_CYCLES     = 16,
  parameter int unsigned PW            = 1,
  parameter int unsigned REPEAT_DELAY  = 1000,
  parameter int unsigned REPEAT_PERIOD = 250
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] trigger,
  input  logic [1:0]   edge_mode,
  output logic [N-1:0] p,
  output logic [N-1:0] level
);

  localparam int unsigned DbW = $clog2(DB_CYCLES) + 1;
  localparam int unsigned PwW = (PW > 1) ? $clog2(PW) : 1;

  if (N < 1 || DB_CYCLES < 1 || PW < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < PW + 1) begin
    : g_param_check
    $error("multi_pulse_generator: illegal parameter combination");
  end

  typedef enum logic {StIdle, StPulse} state_e;

`ifdef MULTI_PULSE_AUTO_REPEAT_EN
  localparam int unsigned HoldMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                   : REPEAT_PERIOD;
  localparam int unsigned HoldW   = $clog2(HoldMax + 1);

  // Previous edge_mode, shared by all channels to detect a mode change.
  logic [1:0] mode_prev_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) mode_prev_q <= 2'b00;
    else          mode_prev_q <= edge_mode;
  end
`endif

  for (genvar i = 0; i < N; i++) begin : g_ch
    logic           s1_q, s2_q;
    logic [DbW-1:0] db_cnt_q, db_cnt_d;
    logic           level_q, level_d, level_prev_q;
    logic           rise, fall, qual, start;
    state_e         state_q, state_d;
    logic [PwW-1:0] pw_cnt_q, pw_cnt_d;
    logic           p_q;

    // Synchroniser and debouncer state.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        s1_q         <= 1'b0;
        s2_q         <= 1'b0;
        db_cnt_q     <= '0;
        level_q      <= 1'b0;
        level_prev_q <= 1'b0;
      end else begin
        s1_q         <= trigger[i];
        s2_q         <= s1_q;
        db_cnt_q     <= db_cnt_d;
        level_q      <= level_d;
        level_prev_q <= level_q;
      end
    end

    // A sample matching level restarts the count; DB_CYCLES mismatches in a row flip it.
    always_comb begin
      db_cnt_d = '0;
      level_d  = level_q;
      if (s2_q != level_q) begin
        if (db_cnt_q == DbW'(DB_CYCLES - 1)) level_d = ~level_q;
        else                                 db_cnt_d = db_cnt_q + 1'b1;
      end
    end

    // Edges are seen the cycle after level flips, so p rises one cycle after level.
    assign rise = level_q & ~level_prev_q;
    assign fall = ~level_q & level_prev_q;

    always_comb begin
      case (edge_mode)
        2'b00:   qual = rise;
        2'b01:   qual = fall;
        2'b10:   qual = rise | fall;
        default: qual = 1'b0;
      endcase
    end

`ifdef MULTI_PULSE_AUTO_REPEAT_EN
    logic [HoldW-1:0] hold_q, hold_d;
    logic             armed_q, armed_d, rep_q, rep_d, rep_fire;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        hold_q  <= '0;
        armed_q <= 1'b0;
        rep_q   <= 1'b0;
      end else begin
        hold_q  <= hold_d;
        armed_q <= armed_d;
        rep_q   <= rep_d;
      end
    end

    // hold counts cycles since the last (edge or repeat) pulse start; rep selects
    // whether the first delay or the period is the current threshold.
    always_comb begin
      hold_d   = hold_q;
      armed_d  = armed_q;
      rep_d    = rep_q;
      rep_fire = 1'b0;
      if (rise | fall) begin
        armed_d = (edge_mode == 2'b00 && rise) || (edge_mode == 2'b01 && fall);
        hold_d  = armed_d ? HoldW'(1) : '0;
        rep_d   = 1'b0;
      end else if (edge_mode != mode_prev_q) begin
        armed_d = 1'b0;
        hold_d  = '0;
        rep_d   = 1'b0;
      end else if (armed_q) begin
        if (hold_q == (rep_q ? HoldW'(REPEAT_PERIOD) : HoldW'(REPEAT_DELAY))) begin
          rep_fire = 1'b1;
          hold_d   = HoldW'(1);
          rep_d    = 1'b1;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
    end

    assign start = qual | rep_fire;
`else
    assign start = qual;
`endif

    // Pulse stretcher: starts while busy are dropped, never queued.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state_q  <= StIdle;
        pw_cnt_q <= '0;
        p_q      <= 1'b0;
      end else begin
        state_q  <= state_d;
        pw_cnt_q <= pw_cnt_d;
        p_q      <= (state_d == StPulse);
      end
    end

    always_comb begin
      state_d  = state_q;
      pw_cnt_d = pw_cnt_q;
      case (state_q)
        StIdle: begin
          if (start) begin
            state_d  = StPulse;
            pw_cnt_d = '0;
          end
        end
        StPulse: begin
          if (pw_cnt_q == PwW'(PW - 1)) begin
            state_d  = StIdle;
            pw_cnt_d = '0;
          end else begin
            pw_cnt_d = pw_cnt_q + 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    assign p[i]     = p_q;
    assign level[i] = level_q;
  end

endmodule

// File: tb/tb_multi_pulse_generator.sv
// Scoreboard bench for multi_pulse_generator. Stimulus pushes every expected pulse
// cycle (instance, edge number, p value) into a queue; a monitor pops one entry for
// every cycle any instance drives a non-zero p. Timing reference: trigger driven at the
// negedge where edge_n == k is first sampled at edge k+1 (t0); p is then high from
// edge k+19 (t0+DB_CYCLES+2 with DB_CYCLES=16) for PW cycles.
module tb_multi_pulse_generator;

`ifdef MULTI_PULSE_AUTO_REPEAT_EN
  localparam int NI = 4;
`else
  localparam int NI = 3;
`endif

  typedef struct {
    int       inst;
    int       cyc;
    logic [3:0] pv;
  } exp_t;

  logic       clk;
  logic       rst_n [NI];
  logic [3:0] trig  [NI];
  logic [1:0] mode  [NI];
  logic [3:0] p_w   [NI];
  logic [3:0] lv    [NI];

  int   edge_n;
  int   n_checks;
  int   n_fail;
  exp_t exp_q[$];

  // Instance 0: defaults (PW=1). Large repeat delay keeps it quiet if the option is built.
  multi_pulse_generator #(.N(4), .DB_CYCLES(16), .PW(1), .REPEAT_DELAY(5000),
                          .REPEAT_PERIOD(10)) dut_a (
    .clk(clk), .reset_n(rst_n[0]), .trigger(trig[0]), .edge_mode(mode[0]),
    .p(p_w[0]), .level(lv[0]));

  multi_pulse_generator #(.N(4), .DB_CYCLES(16), .PW(3), .REPEAT_DELAY(5000),
                          .REPEAT_PERIOD(10)) dut_b (
    .clk(clk), .reset_n(rst_n[1]), .trigger(trig[1]), .edge_mode(mode[1]),
    .p(p_w[1]), .level(lv[1]));

  multi_pulse_generator #(.N(4), .DB_CYCLES(16), .PW(4), .REPEAT_DELAY(5000),
                          .REPEAT_PERIOD(10)) dut_c (
    .clk(clk), .reset_n(rst_n[2]), .trigger(trig[2]), .edge_mode(mode[2]),
    .p(p_w[2]), .level(lv[2]));

`ifdef MULTI_PULSE_AUTO_REPEAT_EN
  multi_pulse_generator #(.N(4), .DB_CYCLES(16), .PW(1), .REPEAT_DELAY(40),
                          .REPEAT_PERIOD(10)) dut_d (
    .clk(clk), .reset_n(rst_n[3]), .trigger(trig[3]), .edge_mode(mode[3]),
    .p(p_w[3]), .level(lv[3]));
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic push(input int inst, input int start, input int width, input logic [3:0] pv);
    for (int j = 0; j < width; j++) begin
      exp_t e;
      e.inst = inst;
      e.cyc  = start + j;
      e.pv   = pv;
      exp_q.push_back(e);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (edge %0d)", name, act, req, edge_n);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_until(input int c);
    while (edge_n < c) @(negedge clk);
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        if (p_w[i] !== 4'b0000) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_pulse: inst %0d p=%b at edge %0d, required none",
                     i, p_w[i], edge_n);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (e.inst != i || e.cyc != edge_n || e.pv !== p_w[i]) begin
              n_fail++;
              $display("FAIL pulse: got inst %0d p=%b edge %0d, required inst %0d p=%b edge %0d",
                       i, p_w[i], edge_n, e.inst, e.pv, e.cyc);
            end
          end
        end
      end
    end
  endtask

  task automatic stimulus();
    int k;
    // Reset state.
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("reset_p%0d", i), 32'(p_w[i]), 32'h0);
      chk($sformatf("reset_level%0d", i), 32'(lv[i]), 32'h0);
    end
    for (int i = 0; i < NI; i++) rst_n[i] = 1'b1;
    wait_cyc(3);

    // Mode 00, ch0 press held 100 cycles: one 1-cycle pulse, none on release.
    k = edge_n;
    trig[0][0] = 1'b1;
    push(0, k + 19, 1, 4'b0001);
    wait_until(k + 17);
    chk("level0_before", 32'(lv[0]), 32'h0);
    wait_until(k + 18);
    chk("level0_after", 32'(lv[0]), 32'h1);
    wait_until(k + 100);
    trig[0][0] = 1'b0;
    wait_cyc(40);

    // Bounce on ch1 every 5 cycles, then stable high.
    k = edge_n;
    for (int s = 0; s < 12; s++) begin
      trig[0][1] = (s % 2 == 0);
      wait_cyc(5);
    end
    k = edge_n;
    trig[0][1] = 1'b1;
    push(0, k + 19, 1, 4'b0010);
    wait_cyc(40);

    // Mode 11 blocks ch3 entirely; mode 01 then pulses on release only.
    mode[0] = 2'b11;
    trig[0][3] = 1'b1;
    wait_cyc(40);
    trig[0][3] = 1'b0;
    wait_cyc(40);
    mode[0] = 2'b01;
    wait_cyc(2);
    trig[0][3] = 1'b1;
    wait_cyc(40);
    k = edge_n;
    trig[0][3] = 1'b0;
    push(0, k + 19, 1, 4'b1000);
    wait_cyc(40);

    // Mode 10, PW=3 on ch2: pulses on press and release.
    k = edge_n;
    trig[1][2] = 1'b1;
    push(1, k + 19, 3, 4'b0100);
    wait_until(k + 50);
    trig[1][2] = 1'b0;
    push(1, k + 69, 3, 4'b0100);
    wait_cyc(40);

    // PW=4: reset during the 2nd pulse cycle, then release with trigger still high.
    k = edge_n;
    trig[2][0] = 1'b1;
    push(2, k + 19, 2, 4'b0001);
    wait_until(k + 20);
    #2 rst_n[2] = 1'b0;
    #1;
    chk("reset_mid_pulse_p", 32'(p_w[2]), 32'h0);
    chk("reset_mid_pulse_level", 32'(lv[2]), 32'h0);
    wait_cyc(3);
    k = edge_n;
    rst_n[2] = 1'b1;
    push(2, k + 19, 4, 4'b0001);
    wait_cyc(40);
    trig[2][0] = 1'b0;
    wait_cyc(30);

`ifdef MULTI_PULSE_AUTO_REPEAT_EN
    // Auto-repeat: delay 40, period 10, released 100 cycles after level rises.
    k = edge_n;
    trig[3][0] = 1'b1;
    push(3, k + 19, 1, 4'b0001);
    for (int m = 0; m < 8; m++) push(3, k + 59 + 10 * m, 1, 4'b0001);
    wait_until(k + 118);
    trig[3][0] = 1'b0;
    wait_cyc(60);
`endif
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < NI; i++) begin
      rst_n[i] = 1'b0;
      trig[i]  = 4'b0000;
      mode[i]  = 2'b00;
    end
    mode[1] = 2'b10;
    #1;
    wait_cyc(3);
    fork
      monitor();
      stimulus();
    join_any
    wait_cyc(5);
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL missed_pulse: got none, required inst %0d p=%b at edge %0d",
               e.inst, e.pv, e.cyc);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
